// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the AHB-side memory targets.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slave_state_e;

    // Byte-lane enables for an aligned transfer of 2**size bytes at lane offset.
    function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] offset);
        logic [7:0] m;
        case (size)
            HSIZE_BYTE: m = 8'h01;
            HSIZE_HALF: m = 8'h03;
            HSIZE_WORD: m = 8'h0F;
            default:    m = 8'hFF;
        endcase
        return m << offset;
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Flop-based word memory: byte-enable synchronous write, combinational read.
module ahb_sram_array
    import ahb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned AW         = 10
) (
    input  logic                    i_clk,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [AW-1:0]           i_waddr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [AW-1:0]           i_raddr,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a flop word memory with configurable wait states,
// sub-word write lanes and a two-cycle ERROR response.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int unsigned        BYTES      = DATA_WIDTH / 8;
    localparam int unsigned        LANE_BITS  = $clog2(BYTES);
    localparam int unsigned        WORD_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] BYTE_SPACE = (ADDR_WIDTH + 1)'(DEPTH * BYTES);

    slave_state_e           r_state, w_next_state;
    logic [2:0]             r_cnt, w_next_cnt;
    logic                   r_dp_valid;
    logic                   r_dp_write;
    logic [2:0]             r_dp_size;
    logic [LANE_BITS-1:0]   r_dp_off;
    logic [WORD_AW-1:0]     r_dp_idx;

    logic                   w_accept;
    logic                   w_err;
    logic                   w_complete;
    logic                   w_we;
    logic [ADDR_WIDTH-1:0]  w_align_mask;
    logic [7:0]             w_mask8;
    logic [BYTES-1:0]       w_be;
    logic [DATA_WIDTH-1:0]  w_rdata;
    logic                   w_unused;

    assign w_unused = ^{HPROT, HTRANS[0]};

    assign HREADYOUT = (r_state == ST_IDLE) || (r_state == ST_ERR2);
    assign HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

    // Own ready also gates acceptance so a misbehaving HREADY cannot clobber a stalled data phase.
    assign w_accept     = HSEL && HREADY && HTRANS[1] && HREADYOUT;
    assign w_align_mask = ADDR_WIDTH'((32'd1 << HSIZE) - 32'd1);
    assign w_err        = (HSIZE > 3'(LANE_BITS))
                       || ((HADDR & w_align_mask) != '0)
                       || ({1'b0, HADDR} >= BYTE_SPACE);

    assign w_complete = r_dp_valid && (r_state == ST_IDLE);
    assign w_we       = w_complete && r_dp_write;
    assign w_mask8    = lane_mask(r_dp_size, 3'(r_dp_off));
    assign w_be       = w_mask8[BYTES-1:0];
    assign HRDATA     = (w_complete && !r_dp_write) ? w_rdata : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_next_state = ST_IDLE;
                if (w_accept) begin
                    if (w_err) begin
                        w_next_state = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_next_state = ST_WAIT;
                        w_next_cnt   = 3'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_cnt = r_cnt - 3'd1;
                end
            end
            ST_ERR1: w_next_state = ST_ERR2;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_size  <= '0;
            r_dp_off   <= '0;
            r_dp_idx   <= '0;
        end else begin
            if (w_accept) begin
                r_dp_valid <= !w_err;
                r_dp_write <= HWRITE;
                r_dp_size  <= HSIZE;
                r_dp_off   <= HADDR[LANE_BITS-1:0];
                r_dp_idx   <= HADDR[LANE_BITS +: WORD_AW];
            end else if (w_complete) begin
                r_dp_valid <= 1'b0;
            end
        end
    end

    ahb_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (WORD_AW)
    ) u_array (
        .i_clk   (HCLK),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_waddr (r_dp_idx),
        .i_wdata (HWDATA),
        .i_raddr (r_dp_idx),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed scoreboard bench: one zero-wait and one three-wait instance on a shared bus.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam int unsigned WS3 = 3;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b1;
    logic        hsel;
    logic        use3;
    logic [15:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;

    logic        HSEL0, HSEL3, HREADY0, HREADY3;
    logic        HREADYOUT0, HREADYOUT3, HRESP0, HRESP3;
    logic [31:0] HRDATA0, HRDATA3;
    logic        ready, resp;
    logic [31:0] rdata;

    always #5 HCLK = ~HCLK;

    assign HSEL0   = hsel & ~use3;
    assign HSEL3   = hsel & use3;
    assign HREADY0 = HREADYOUT0;
    assign HREADY3 = HREADYOUT3;
    assign ready   = use3 ? HREADYOUT3 : HREADYOUT0;
    assign resp    = use3 ? HRESP3 : HRESP0;
    assign rdata   = use3 ? HRDATA3 : HRDATA0;

    ahb_sram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL0), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY0),
        .HREADYOUT(HREADYOUT0), .HRESP(HRESP0), .HRDATA(HRDATA0)
    );

    ahb_sram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(1024), .WAIT_STATES(WS3)) u_dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL3), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY3),
        .HREADYOUT(HREADYOUT3), .HRESP(HRESP3), .HRDATA(HRDATA3)
    );

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        int unsigned waits;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr(input string tag, input logic w, input logic [15:0] a,
                        input logic [2:0] sz, input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        hsel   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = w;
        HADDR  = a;
        HSIZE  = sz;
        e.tag   = tag;
        e.data  = (w || exp_err) ? 32'h0 : exp_data;
        e.err   = exp_err;
        e.waits = exp_err ? 1 : (use3 ? WS3 : 0);
        sb.push_back(e);
    endtask

    task automatic idle();
        hsel   = 1'b0;
        HTRANS = 2'b00;
    endtask

    task automatic dphase(input logic [31:0] wd);
        exp_t        e;
        int unsigned waits;
        bit          done;
        waits  = 0;
        done   = 1'b0;
        HWDATA = wd;
        e = sb.pop_front();
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge HCLK);
            if (ready) begin
                done = 1'b1;
            end else begin
                waits++;
                chk({e.tag, "_wait_resp"}, 32'(resp), 32'(e.err));
                chk({e.tag, "_wait_rdata"}, rdata, 32'h0);
            end
        end
        chk({e.tag, "_done"}, 32'(done), 32'd1);
        chk({e.tag, "_waits"}, waits, e.waits);
        chk({e.tag, "_resp"}, 32'(resp), 32'(e.err));
        chk({e.tag, "_rdata"}, rdata, e.data);
        step();
    endtask

    initial begin
        hsel = 1'b0; use3 = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
        HSIZE = 3'd2; HPROT = 4'h3; HWDATA = '0;
        #1 HRESETn = 1'b0;
        #11;
        chk("rst_ready0", 32'(HREADYOUT0), 32'd1);
        chk("rst_resp0", 32'(HRESP0), 32'd0);
        chk("rst_rdata0", HRDATA0, 32'h0);
        chk("rst_ready3", 32'(HREADYOUT3), 32'd1);
        chk("rst_resp3", 32'(HRESP3), 32'd0);
        step();
        HRESETn = 1'b1;
        step();

        // Back-to-back write then read at zero wait states
        addr("wr_dead", 1'b1, 16'h0010, 3'd2, 32'h0, 1'b0);
        step();
        addr("rd_dead", 1'b0, 16'h0010, 3'd2, 32'hDEADBEEF, 1'b0);
        dphase(32'hDEADBEEF);
        idle();
        dphase(32'h0);

        // Byte and halfword lanes
        addr("wr_word", 1'b1, 16'h0010, 3'd2, 32'h0, 1'b0);
        step();
        addr("wr_byte", 1'b1, 16'h0013, 3'd0, 32'h0, 1'b0);
        dphase(32'h11223344);
        addr("rd_byte", 1'b0, 16'h0010, 3'd2, 32'hAA223344, 1'b0);
        dphase(32'hAA5A5A5A);
        idle();
        dphase(32'h0);
        addr("wr_w0", 1'b1, 16'h0000, 3'd2, 32'h0, 1'b0);
        step();
        addr("wr_half", 1'b1, 16'h0002, 3'd1, 32'h0, 1'b0);
        dphase(32'h01020304);
        idle();
        dphase(32'hBEEF7777);

        // Error responses; the read is accepted during the second ERROR cycle
        addr("err_misal", 1'b1, 16'h0002, 3'd2, 32'h0, 1'b1);
        step();
        idle();
        dphase(32'hFFFFFFFF);
        addr("err_range", 1'b1, 16'h1000, 3'd2, 32'h0, 1'b1);
        step();
        addr("rd_w0", 1'b0, 16'h0000, 3'd2, 32'hBEEF0304, 1'b0);
        dphase(32'hFFFFFFFF);
        idle();
        dphase(32'h0);
        addr("err_dword", 1'b0, 16'h0018, 3'd3, 32'h0, 1'b1);
        step();
        idle();
        dphase(32'h0);
        addr("err_rd_range", 1'b0, 16'hFFFC, 3'd2, 32'h0, 1'b1);
        step();
        idle();
        dphase(32'h0);
        addr("rd_w4", 1'b0, 16'h0010, 3'd2, 32'hAA223344, 1'b0);
        step();
        idle();
        dphase(32'h0);

        // Selected but IDLE, then BUSY
        hsel = 1'b1; HTRANS = 2'b00; HADDR = 16'h0010; HWRITE = 1'b0; HSIZE = 3'd2;
        step();
        @(negedge HCLK);
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_resp", 32'(resp), 32'd0);
        chk("idle_rdata", rdata, 32'h0);
        step();
        HTRANS = 2'b01;
        step();
        @(negedge HCLK);
        chk("busy_ready", 32'(ready), 32'd1);
        chk("busy_resp", 32'(resp), 32'd0);
        chk("busy_rdata", rdata, 32'h0);
        step();
        idle();
        step();

        // Three wait states
        use3 = 1'b1;
        addr("ws3_wr", 1'b1, 16'h0020, 3'd2, 32'h0, 1'b0);
        step();
        idle();
        dphase(32'hCAFEF00D);
        addr("ws3_rd", 1'b0, 16'h0020, 3'd2, 32'hCAFEF00D, 1'b0);
        step();
        idle();
        dphase(32'h0);
        addr("ws3_wr24", 1'b1, 16'h0024, 3'd2, 32'h0, 1'b0);
        step();
        addr("ws3_rd24", 1'b0, 16'h0024, 3'd2, 32'h5555AAAA, 1'b0);
        dphase(32'h5555AAAA);
        idle();
        dphase(32'h0);
        addr("ws3_err", 1'b1, 16'h0021, 3'd1, 32'h0, 1'b1);
        step();
        idle();
        dphase(32'h0);

        // Reset during the wait phase of a write
        hsel = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 16'h0020; HSIZE = 3'd2;
        step();
        idle();
        HWDATA = 32'h12345678;
        @(negedge HCLK);
        chk("rstw_in_wait", 32'(HREADYOUT3), 32'd0);
        #1 HRESETn = 1'b0;
        #1;
        chk("rstw_ready", 32'(HREADYOUT3), 32'd1);
        chk("rstw_resp", 32'(HRESP3), 32'd0);
        chk("rstw_rdata", HRDATA3, 32'h0);
        step();
        step();
        HRESETn = 1'b1;
        step();
        addr("rd_after_rst", 1'b0, 16'h0020, 3'd2, 32'hCAFEF00D, 1'b0);
        step();
        idle();
        dphase(32'h0);
        use3 = 1'b0;
        addr("rd0_after_rst", 1'b0, 16'h0010, 3'd2, 32'hAA223344, 1'b0);
        step();
        idle();
        dphase(32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

Parametrised AHB-Lite slave fronting a flop-based word memory; the next generation of the team's fixed 16-bit-address / 32-bit-data AHB attachment. It adds configurable data width, memory depth and wait-state insertion, plus byte/halfword write lanes and a two-cycle ERROR response. It sits behind the AHB decoder and is the memory target for the AHB side of the AHB/APB memory bench.

## Interface
- ADDR_WIDTH, 16, HADDR width in bits (byte address).
- DATA_WIDTH, 32, HWDATA/HRDATA width; one of 32 or 64.
- DEPTH, 1024, number of DATA_WIDTH words; byte space is DEPTH*DATA_WIDTH/8 and must fit in ADDR_WIDTH.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY transfer; 0..7.

Ports:
- HCLK  in  1  clock; all state updates on rising edge.
- HRESETn  in  1  reset; asynchronous, active-low.
- HSEL  in  1  slave select from decoder.
- HADDR  in  ADDR_WIDTH  byte address, address phase.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, bytes = 2**HSIZE.
- HPROT  in  4  accepted, ignored.
- HWDATA  in  DATA_WIDTH  write data, data phase.
- HREADY  in  1  bus-level ready (mux of all HREADYOUTs).
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  DATA_WIDTH  read data.

## Operation
- Transfer accepted when HSEL && HREADY && HTRANS[1] at a rising edge; HADDR, HWRITE, HSIZE captured into data-phase registers.
- IDLE/BUSY or unselected: no data phase follows; bus sees zero-wait OKAY.
- Error check at acceptance, any one sets ERROR: 2**HSIZE > DATA_WIDTH/8; HADDR not aligned to 2**HSIZE; HADDR >= DEPTH*DATA_WIDTH/8.
- FSM states: ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2.
  - ST_IDLE: HREADYOUT=1, HRESP=0. On valid accept -> ST_WAIT if WAIT_STATES>0 (counter loaded WAIT_STATES-1), else completes next cycle in ST_IDLE. On erroneous accept -> ST_ERR1.
  - ST_WAIT: HREADYOUT=0, counter decrements; at 0 -> ST_IDLE (completion cycle, HREADYOUT=1).
  - ST_ERR1: HREADYOUT=0, HRESP=1 -> ST_ERR2.
  - ST_ERR2: HREADYOUT=1, HRESP=1 -> ST_IDLE; a new transfer may be accepted in this cycle.
- Write: byte lanes = 2**HSIZE bytes starting at HADDR mod (DATA_WIDTH/8); HWDATA on those lanes written at the edge ending the completing data-phase cycle. Other lanes untouched. Errored writes never modify memory.
- Read: in completing cycle, HRDATA = full word at captured word index (all lanes driven, regardless of HSIZE); otherwise HRDATA = 0. Errored reads return 0.
- Read-after-write back-to-back: the array is read combinationally, so the read's data phase returns the just-written value.
- Memory contents are not reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state ST_IDLE, counter 0, data-phase valid 0.
- OKAY latency: address phase + (WAIT_STATES+1) data-phase cycles.
- ERROR: exactly two data-phase cycles, independent of WAIT_STATES.
- Pipelining: next address phase is accepted in the cycle HREADYOUT=1 completes the current one; no cycle lost at WAIT_STATES=0.
- HWDATA sampled only in the completing cycle (HREADYOUT=1).
- Reset asserted mid-transfer: pending write discarded, outputs return to reset values immediately (asynchronously).

## Structure
- Shared package ahb_pkg: htrans_e, hsize_e (BYTE=0, HALF=1, WORD=2, DWORD=3), HRESP_OKAY/HRESP_ERROR constants, slave_state_e.
- One sub-module, ahb_sram_array: DEPTH x DATA_WIDTH flops, byte-enable write port, combinational read port.
- Top holds FSM, wait counter, address/control capture, lane decode.

## Test plan
- WAIT_STATES=0: NONSEQ write 0xDEADBEEF @0x0010, then NONSEQ read @0x0010 back-to-back -> HREADYOUT stays 1, read data phase HRDATA=0xDEADBEEF, HRESP=0.
- Byte write 0xAA (HSIZE=0) @0x0013 over word 0x11223344 -> read @0x0010 returns 0xAA223344.
- WAIT_STATES=3: single read -> exactly 3 cycles HREADYOUT=0, then 1 with valid data.
- HSIZE=2 @0x0002 (misaligned) and word @0x1000 (DEPTH=1024) -> each gives HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1; memory unchanged.
- HSEL=1 with HTRANS=IDLE, then BUSY -> no state change, HREADYOUT=1, HRESP=0.
- HRESETn low during ST_WAIT of a write -> outputs at reset values that cycle; subsequent read of that address shows old data.
